// File: rtl/decode_stage.sv
// Decode stage: decodes IF/ID, resolves operands via EX/MEM/WB forwarding, resolves branches, registers ID/EX.
// Latency: decode, forwarding, stall and branch outputs are combinational; ID/EX results appear 1 cycle later.
// Backpressure: a load-use hazard raises stall, holds fetch and injects a bubble into ID/EX.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] fe_pc,
    input  logic [31:0] fe_inst,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        ex_wen,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    input  logic        ex_is_load,
    input  logic        mem_wen,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic        wb_wen,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    output logic        stall,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        de_valid,
    output logic [31:0] de_pc,
    output logic [3:0]  de_alu_op,
    output logic [31:0] de_src1,
    output logic [31:0] de_src2,
    output logic        de_rf_wen,
    output logic [4:0]  de_dest,
    output logic        de_mem_read,
    output logic        de_mem_wen,
    output logic [31:0] de_store_data
);

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    // SPECIAL function codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    // ALU operation codes seen by the execute stage
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    typedef enum logic [1:0] {S1_ZERO, S1_RS, S1_SA, S1_PC} src1_sel_e;
    typedef enum logic [2:0] {S2_ZERO, S2_RT, S2_SIMM, S2_ZIMM, S2_EIGHT} src2_sel_e;

    // Instruction fields
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] jindex;

    assign opcode = fe_inst[31:26];
    assign rs     = fe_inst[25:21];
    assign rt     = fe_inst[20:16];
    assign rd     = fe_inst[15:11];
    assign sa     = fe_inst[10:6];
    assign funct  = fe_inst[5:0];
    assign imm    = fe_inst[15:0];
    assign jindex = fe_inst[25:0];

    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    // Decoded control
    logic       r_alu;
    logic       r_shift;
    logic       use_rs;
    logic       use_rt;
    logic       has_dest;
    logic [4:0] dest_c;
    logic [3:0] alu_op_c;
    logic       mem_read_c;
    logic       mem_wen_c;
    logic       is_beq;
    logic       is_bne;
    logic       is_jump;
    logic       is_jr;
    src1_sel_e  src1_sel;
    src2_sel_e  src2_sel;

    // Instruction decode; unrecognised encodings fall through as a NOP via the defaults
    always_comb begin
        r_alu      = 1'b0;
        r_shift    = 1'b0;
        use_rs     = 1'b0;
        use_rt     = 1'b0;
        has_dest   = 1'b0;
        dest_c     = 5'd0;
        alu_op_c   = ALU_ADD;
        mem_read_c = 1'b0;
        mem_wen_c  = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_jump    = 1'b0;
        is_jr      = 1'b0;
        src1_sel   = S1_ZERO;
        src2_sel   = S2_ZERO;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    F_ADDU: begin r_alu   = 1'b1; alu_op_c = ALU_ADD;  end
                    F_SUBU: begin r_alu   = 1'b1; alu_op_c = ALU_SUB;  end
                    F_AND:  begin r_alu   = 1'b1; alu_op_c = ALU_AND;  end
                    F_OR:   begin r_alu   = 1'b1; alu_op_c = ALU_OR;   end
                    F_XOR:  begin r_alu   = 1'b1; alu_op_c = ALU_XOR;  end
                    F_NOR:  begin r_alu   = 1'b1; alu_op_c = ALU_NOR;  end
                    F_SLT:  begin r_alu   = 1'b1; alu_op_c = ALU_SLT;  end
                    F_SLTU: begin r_alu   = 1'b1; alu_op_c = ALU_SLTU; end
                    F_SLL:  begin r_shift = 1'b1; alu_op_c = ALU_SLL;  end
                    F_SRL:  begin r_shift = 1'b1; alu_op_c = ALU_SRL;  end
                    F_SRA:  begin r_shift = 1'b1; alu_op_c = ALU_SRA;  end
                    F_JR: begin
                        is_jr  = 1'b1;
                        use_rs = 1'b1;
                    end
                    default: ;
                endcase
                if (r_alu || r_shift) begin
                    use_rs   = r_alu;
                    use_rt   = 1'b1;
                    has_dest = 1'b1;
                    dest_c   = rd;
                    src1_sel = r_shift ? S1_SA : S1_RS;
                    src2_sel = S2_RT;
                end
            end
            OP_ADDIU: begin
                use_rs   = 1'b1;
                has_dest = 1'b1;
                dest_c   = rt;
                src1_sel = S1_RS;
                src2_sel = S2_SIMM;
            end
            OP_LUI: begin
                alu_op_c = ALU_LUI;
                has_dest = 1'b1;
                dest_c   = rt;
                src2_sel = S2_ZIMM;
            end
            OP_LW: begin
                use_rs     = 1'b1;
                has_dest   = 1'b1;
                dest_c     = rt;
                mem_read_c = 1'b1;
                src1_sel   = S1_RS;
                src2_sel   = S2_SIMM;
            end
            OP_SW: begin
                use_rs    = 1'b1;
                use_rt    = 1'b1;
                dest_c    = rt;
                mem_wen_c = 1'b1;
                src1_sel  = S1_RS;
                src2_sel  = S2_SIMM;
            end
            OP_BEQ: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                is_beq = 1'b1;
            end
            OP_BNE: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                is_bne = 1'b1;
            end
            OP_J: begin
                is_jump = 1'b1;
            end
            OP_JAL: begin
                is_jump  = 1'b1;
                has_dest = 1'b1;
                dest_c   = 5'd31;
                src1_sel = S1_PC;
                src2_sel = S2_EIGHT;
            end
            default: ;
        endcase
    end

    // Youngest producer wins; a load still in EX has no data yet so it is skipped here
    function automatic logic [31:0] forward(
        input logic [4:0]  r,
        input logic [31:0] rf_val,
        input logic        exw,
        input logic        exl,
        input logic [4:0]  exa,
        input logic [31:0] exd,
        input logic        mw,
        input logic [4:0]  ma,
        input logic [31:0] md,
        input logic        ww,
        input logic [4:0]  wa,
        input logic [31:0] wd
    );
        logic [31:0] v;
        if (r == 5'd0)                    v = 32'd0;
        else if (exw && !exl && exa == r) v = exd;
        else if (mw && ma == r)           v = md;
        else if (ww && wa == r)           v = wd;
        else                              v = rf_val;
        return v;
    endfunction

    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    assign fwd_rs = forward(rs, rf_rdata1, ex_wen, ex_is_load, ex_waddr, ex_wdata,
                            mem_wen, mem_waddr, mem_wdata, wb_wen, wb_waddr, wb_wdata);
    assign fwd_rt = forward(rt, rf_rdata2, ex_wen, ex_is_load, ex_waddr, ex_wdata,
                            mem_wen, mem_waddr, mem_wdata, wb_wen, wb_waddr, wb_wdata);

    // Load-use hazard: only sources the instruction really reads can stall it
    logic hit_rs;
    logic hit_rt;

    assign hit_rs = use_rs && (ex_waddr == rs);
    assign hit_rt = use_rt && (ex_waddr == rt);
    assign stall  = ex_wen && ex_is_load && (ex_waddr != 5'd0) && (hit_rs || hit_rt);

    // Branch and jump resolution; a stalled instruction must not redirect yet
    logic [31:0] pc_plus4;
    logic        br_cond;

    assign pc_plus4 = fe_pc + 32'd4;

    // Redirect decision and target selection
    always_comb begin
        br_cond   = 1'b0;
        br_target = pc_plus4;
        if (is_beq || is_bne) begin
            br_cond   = is_beq ? (fwd_rs == fwd_rt) : (fwd_rs != fwd_rt);
            br_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
        end else if (is_jump) begin
            br_cond   = 1'b1;
            br_target = {pc_plus4[31:28], jindex, 2'b00};
        end else if (is_jr) begin
            br_cond   = 1'b1;
            br_target = fwd_rs;
        end
    end

    assign br_taken = br_cond && !stall;

    // ALU operand selection
    logic [31:0] src1_c;
    logic [31:0] src2_c;

    // Operand muxes driven by the decoded source selects
    always_comb begin
        src1_c = 32'd0;
        src2_c = 32'd0;
        case (src1_sel)
            S1_RS:   src1_c = fwd_rs;
            S1_SA:   src1_c = {27'd0, sa};
            S1_PC:   src1_c = fe_pc;
            default: src1_c = 32'd0;
        endcase
        case (src2_sel)
            S2_RT:    src2_c = fwd_rt;
            S2_SIMM:  src2_c = {{16{imm[15]}}, imm};
            S2_ZIMM:  src2_c = {16'd0, imm};
            S2_EIGHT: src2_c = 32'd8;
            default:  src2_c = 32'd0;
        endcase
    end

    // ID/EX pipeline register
    logic        de_valid_q,      de_valid_d;
    logic [31:0] de_pc_q,         de_pc_d;
    logic [3:0]  de_alu_op_q,     de_alu_op_d;
    logic [31:0] de_src1_q,       de_src1_d;
    logic [31:0] de_src2_q,       de_src2_d;
    logic        de_rf_wen_q,     de_rf_wen_d;
    logic [4:0]  de_dest_q,       de_dest_d;
    logic        de_mem_read_q,   de_mem_read_d;
    logic        de_mem_wen_q,    de_mem_wen_d;
    logic [31:0] de_store_data_q, de_store_data_d;

    // Next ID/EX contents: the decoded instruction, or an all-zero bubble while stalled
    always_comb begin
        de_valid_d      = 1'b0;
        de_pc_d         = fe_pc;
        de_alu_op_d     = 4'd0;
        de_src1_d       = 32'd0;
        de_src2_d       = 32'd0;
        de_rf_wen_d     = 1'b0;
        de_dest_d       = 5'd0;
        de_mem_read_d   = 1'b0;
        de_mem_wen_d    = 1'b0;
        de_store_data_d = 32'd0;
        if (!stall) begin
            de_valid_d      = 1'b1;
            de_alu_op_d     = alu_op_c;
            de_src1_d       = src1_c;
            de_src2_d       = src2_c;
            de_rf_wen_d     = has_dest && (dest_c != 5'd0);
            de_dest_d       = dest_c;
            de_mem_read_d   = mem_read_c;
            de_mem_wen_d    = mem_wen_c;
            de_store_data_d = fwd_rt;
        end
    end

    // ID/EX state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            de_valid_q      <= 1'b0;
            de_pc_q         <= RESET_PC;
            de_alu_op_q     <= 4'd0;
            de_src1_q       <= 32'd0;
            de_src2_q       <= 32'd0;
            de_rf_wen_q     <= 1'b0;
            de_dest_q       <= 5'd0;
            de_mem_read_q   <= 1'b0;
            de_mem_wen_q    <= 1'b0;
            de_store_data_q <= 32'd0;
        end else begin
            de_valid_q      <= de_valid_d;
            de_pc_q         <= de_pc_d;
            de_alu_op_q     <= de_alu_op_d;
            de_src1_q       <= de_src1_d;
            de_src2_q       <= de_src2_d;
            de_rf_wen_q     <= de_rf_wen_d;
            de_dest_q       <= de_dest_d;
            de_mem_read_q   <= de_mem_read_d;
            de_mem_wen_q    <= de_mem_wen_d;
            de_store_data_q <= de_store_data_d;
        end
    end

    assign de_valid      = de_valid_q;
    assign de_pc         = de_pc_q;
    assign de_alu_op     = de_alu_op_q;
    assign de_src1       = de_src1_q;
    assign de_src2       = de_src2_q;
    assign de_rf_wen     = de_rf_wen_q;
    assign de_dest       = de_dest_q;
    assign de_mem_read   = de_mem_read_q;
    assign de_mem_wen    = de_mem_wen_q;
    assign de_store_data = de_store_data_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second stage of the 5-stage MIPS pipeline. Consumes the IF/ID pair (fe_pc, fe_inst) and decodes the instruction.
- Reads the register file and resolves operands through forwarding from EX/MEM/WB.
- Resolves branches and jumps in ID (architectural delay slot, no flush), detects load-use hazards, and drives the fetch stall.
- Registers all decoded results into the ID/EX pipeline register feeding the execute stage.

Parameters:
- RESET_PC, 32'hbfc00000, reset value of de_pc.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- fe_pc  in  32  PC of the instruction in IF/ID
- fe_inst  in  32  instruction in IF/ID
- rf_raddr1  out  5  register file read address (rs)
- rf_raddr2  out  5  register file read address (rt)
- rf_rdata1  in  32  combinational read data for rf_raddr1
- rf_rdata2  in  32  combinational read data for rf_raddr2
- ex_wen  in  1  EX stage writes a register
- ex_waddr  in  5  EX destination
- ex_wdata  in  32  EX ALU result
- ex_is_load  in  1  EX instruction is LW
- mem_wen  in  1  MEM stage writes a register
- mem_waddr  in  5  MEM destination
- mem_wdata  in  32  MEM result (load data valid)
- wb_wen  in  1  WB stage writes a register
- wb_waddr  in  5  WB destination
- wb_wdata  in  32  WB result
- stall  out  1  load-use hazard; fetch holds fe_pc/fe_inst
- br_taken  out  1  redirect PC
- br_target  out  32  redirect address
- de_valid  out  1  ID/EX holds a real instruction
- de_pc  out  32  PC of the instruction
- de_alu_op  out  4  ALU operation
- de_src1  out  32  ALU operand 1
- de_src2  out  32  ALU operand 2
- de_rf_wen  out  1  register write enable
- de_dest  out  5  destination register
- de_mem_read  out  1  LW
- de_mem_wen  out  1  SW
- de_store_data  out  32  forwarded rt value for SW

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk. On reset: de_pc=RESET_PC; all other de_* outputs = 0.
- Decode and operand logic is combinational on fe_inst. ID/EX registers update at the next posedge; latency is 1 cycle.
- rf_raddr1 = fe_inst[25:21]; rf_raddr2 = fe_inst[20:16].
- Supported instructions: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, JR, ADDIU, LUI, LW, SW, BEQ, BNE, J, JAL.
- Any other encoding decodes as a NOP: de_valid=1, de_rf_wen=0, de_mem_read=0, de_mem_wen=0.
- ALU op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI.
- Operands:
  - R-type: src1=rs, src2=rt.
  - Shifts: src1=zero-extended sa, src2=rt.
  - ADDIU/LW/SW: src2 = sign-extended imm.
  - LUI: src2 = zero-extended imm.
  - JAL: src1=fe_pc, src2=8, op ADD.
- Destinations: R-type → rd; I-type → rt; JAL → 31. de_rf_wen is forced to 0 when the destination is 0, so fe_inst=0 is a NOP.
- Forwarding, per source: register 0 always reads 0. Otherwise the first match wins, in this priority: EX (wen and waddr match, not load) > MEM > WB > rf_rdata.
- Load-use stall: stall=1 when ex_wen & ex_is_load & ex_waddr≠0 & ex_waddr matches a source actually used by the instruction.
  - Sources used: rs by all except J, JAL, LUI, shifts; rt by R-type, SW, BEQ, BNE.
  - While stalled, ID/EX loads a bubble (de_valid=0, de_rf_wen=0, de_mem_*=0) and br_taken=0.
  - Fetch holds, so the instruction is re-decoded the next cycle with MEM-stage forwarding.
- Branch/jump targets:
  - BEQ/BNE: br_taken = (fwd_rs == fwd_rt) for BEQ, the inverse for BNE. br_target = fe_pc + 4 + (sext(imm) << 2), modulo 2^32.
  - J/JAL: br_taken=1, br_target = {fe_pc+4 [31:28], index, 2'b00}.
  - JR: br_taken=1, br_target = fwd_rs.
- Branches do not flush; the delay-slot instruction proceeds.
- Reset mid-stall: reset wins; ID/EX is cleared and stall depends only on the current inputs.

Test Plan:
- Reset with fe_inst=0 → after the edge, de_pc=BFC00000, de_valid=0. Next cycle: de_valid=1, de_rf_wen=0 (NOP).
- ADDU $3,$1,$2 with rf_rdata1=5, rf_rdata2=7 and no forwarding hits → de_alu_op=0, src1=5, src2=7, dest=3, de_rf_wen=1.
- Same ADDU with ex_wen=1, ex_waddr=1, ex_wdata=9, plus mem_waddr=1, mem_wdata=4 → de_src1=9 (EX priority). With ex_waddr=0 and mem_waddr=0 → src1=5.
- LW $4 in EX (ex_is_load=1, waddr=4), fe_inst = ADDU $5,$4,$0 → stall=1 and a bubble. Next cycle (mem_waddr=4, mem_wdata=0x55, ex idle) → stall=0, de_src1=0x55.
- BEQ at fe_pc=0xBFC00010, imm=0xFFFF, rs=rt=3 → br_taken=1, br_target=0xBFC00010. With rs≠rt → br_taken=0.
- JAL index=0x0100000 at fe_pc=0xBFC00020 → br_target=0xB0400000, de_dest=31, src1=0xBFC00020, src2=8. JR $31 with WB forwarding 0x80001234 → br_target=0x80001234.
